mips_cpu_axi_mem_bridge: RTL
============================

Name: mips_cpu_axi_mem_bridge

Overview:
AXI4-Lite slave that terminates the host (PS) register/memory window of the MIPS evaluation platform and converts it into single-port synchronous memory accesses. It sits directly downstream of the FPGA top-level AXI ports (14-bit address), inside the CPU core wrapper, and drives the host-side port of the instruction/data memory. It handles one transaction at a time; writes take priority over reads.

Parameters:
ADDR_WIDTH, 14, AXI byte-address width.
MEM_WORDS, 4096, implemented memory depth in 32-bit words; word index >= MEM_WORDS returns SLVERR.
RD_LATENCY, 1, cycles from mem_ren to valid mem_rdata (1 or 2).

Ports:
mips_cpu_clk  in  1  clock
mips_cpu_reset_n  in  1  asynchronous active-low reset
mips_cpu_axi_if_awaddr  in  ADDR_WIDTH  write address
mips_cpu_axi_if_awvalid  in  1  write address valid
mips_cpu_axi_if_awready  out  1  write address ready
mips_cpu_axi_if_wdata  in  32  write data
mips_cpu_axi_if_wstrb  in  4  write byte strobes
mips_cpu_axi_if_wvalid  in  1  write data valid
mips_cpu_axi_if_wready  out  1  write data ready
mips_cpu_axi_if_bresp  out  2  write response (00 OKAY, 10 SLVERR)
mips_cpu_axi_if_bvalid  out  1  write response valid
mips_cpu_axi_if_bready  in  1  write response ready
mips_cpu_axi_if_araddr  in  ADDR_WIDTH  read address
mips_cpu_axi_if_arvalid  in  1  read address valid
mips_cpu_axi_if_arready  out  1  read address ready
mips_cpu_axi_if_rdata  out  32  read data
mips_cpu_axi_if_rresp  out  2  read response
mips_cpu_axi_if_rvalid  out  1  read data valid
mips_cpu_axi_if_rready  in  1  read data ready
mem_addr  out  ADDR_WIDTH-2  word address to memory
mem_wen  out  1  write enable, one-cycle pulse
mem_wstrb  out  4  byte enables (valid with mem_wen)
mem_wdata  out  32  write data
mem_ren  out  1  read enable, one-cycle pulse
mem_rdata  in  32  read data, valid RD_LATENCY cycles after mem_ren

Behaviour:
- Reset: all ready/valid outputs 0, bresp/rresp 00, rdata 0, mem_wen/mem_ren 0, mem_addr/mem_wdata/mem_wstrb 0; FSM to IDLE; latched AW/W flags cleared. Reset mid-transaction abandons it; no response is issued afterwards.
- All outputs are registered; ready signals must not depend combinationally on valid.
- States: IDLE, WR_COLLECT, WR_MEM, WR_RESP, RD_MEM, RD_WAIT, RD_RESP.
- IDLE: awready=wready=1, arready=0. The AW and W handshakes are independent and may occur in either order or in the same cycle; each is latched and its ready drops the cycle after capture. Once either is captured -> WR_COLLECT, where the other is awaited (arready stays 0).
- Read accepted only in IDLE with no AW/W captured and awvalid=wvalid=0 in that cycle: arready asserted for one cycle, then -> RD_MEM. If awvalid and arvalid rise together, the write wins; the read waits.
- WR_MEM (1 cycle): if word index < MEM_WORDS, mem_wen=1 with latched addr[ADDR_WIDTH-1:2], wdata, and wstrb; otherwise no mem_wen and bresp=10. -> WR_RESP. wstrb=0000 is OKAY and pulses mem_wen with zero strobes.
- WR_RESP: bvalid=1 held until bready; on handshake -> IDLE, with awready/wready re-asserted the next cycle.
- RD_MEM (1 cycle): mem_ren=1 if in range. -> RD_WAIT for RD_LATENCY cycles. Capture mem_rdata into rdata with rresp=00; out-of-range reads capture rdata=0 and rresp=10. -> RD_RESP.
- RD_RESP: rvalid=1, rdata stable until rready; on handshake -> IDLE.
- awaddr/araddr[1:0] ignored (word aligned). Minimum write-to-bvalid latency from the last of AW/W: 2 cycles. Minimum ar-handshake-to-rvalid latency: RD_LATENCY+2 cycles.
- mem_wen and mem_ren are never asserted in the same cycle; at most one outstanding transaction.

Test Plan:
- Reset then AW(0x0010)+W(0xDEADBEEF, strb 1111) in the same cycle -> one mem_wen with mem_addr=0x004, wdata=0xDEADBEEF; bvalid 2 cycles later with bresp=00.
- W first, AW 3 cycles later (addr 0x0020, strb 0011) -> wready drops after W capture; single mem_wen with mem_addr=0x008, wstrb=0011; OKAY response.
- Read 0x0010 with memory returning 0xDEADBEEF (RD_LATENCY=1) -> mem_ren pulses once; rvalid 3 cycles after the ar handshake, rdata=0xDEADBEEF, rresp=00; rready held low 5 cycles keeps rdata stable.
- MEM_WORDS=1024, read 0x1000 and write 0x1FFC -> no mem_ren/mem_wen; rresp=10 with rdata=0, bresp=10.
- awvalid, wvalid and arvalid asserted together -> write completes first (bvalid before arready); the read is then served with correct data.
- Assert reset during RD_WAIT -> rvalid stays 0 and all outputs return to reset values; a fresh read after reset completes normally.

Source files
------------

// File: rtl/mips_cpu_axi_mem_bridge.sv
// AXI4-Lite slave to single-port synchronous memory bridge, one transaction at a time, writes before reads.
// Latency: bvalid 2 cycles after the last of AW/W; rvalid RD_LATENCY+2 cycles after the AR handshake.
// Backpressure: bvalid/rvalid hold until bready/rready; no new address is accepted until the response completes.
module mips_cpu_axi_mem_bridge #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned MEM_WORDS  = 4096,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  mips_cpu_clk,
    input  logic                  mips_cpu_reset_n,
    input  logic [ADDR_WIDTH-1:0] mips_cpu_axi_if_awaddr,
    input  logic                  mips_cpu_axi_if_awvalid,
    output logic                  mips_cpu_axi_if_awready,
    input  logic [31:0]           mips_cpu_axi_if_wdata,
    input  logic [3:0]            mips_cpu_axi_if_wstrb,
    input  logic                  mips_cpu_axi_if_wvalid,
    output logic                  mips_cpu_axi_if_wready,
    output logic [1:0]            mips_cpu_axi_if_bresp,
    output logic                  mips_cpu_axi_if_bvalid,
    input  logic                  mips_cpu_axi_if_bready,
    input  logic [ADDR_WIDTH-1:0] mips_cpu_axi_if_araddr,
    input  logic                  mips_cpu_axi_if_arvalid,
    output logic                  mips_cpu_axi_if_arready,
    output logic [31:0]           mips_cpu_axi_if_rdata,
    output logic [1:0]            mips_cpu_axi_if_rresp,
    output logic                  mips_cpu_axi_if_rvalid,
    input  logic                  mips_cpu_axi_if_rready,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic                  mem_wen,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    output logic                  mem_ren,
    input  logic [31:0]           mem_rdata
);
    localparam int unsigned IDX_W = ADDR_WIDTH - 2;

    typedef enum logic [2:0] {
        IDLE, WR_COLLECT, WR_MEM, WR_RESP, RD_MEM, RD_WAIT, RD_RESP
    } state_t;

    state_t           state;
    logic             aw_got;
    logic             w_got;
    logic [IDX_W-1:0] addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic [1:0]       lat_cnt;

    logic aw_hs;
    logic w_hs;
    logic aw_next;
    logic w_next;
    logic addr_ok;
    logic unused_addr_lsbs;

    assign aw_hs   = mips_cpu_axi_if_awvalid & mips_cpu_axi_if_awready;
    assign w_hs    = mips_cpu_axi_if_wvalid & mips_cpu_axi_if_wready;
    assign aw_next = aw_got | aw_hs;
    assign w_next  = w_got | w_hs;
    assign addr_ok = (32'(addr_q) < MEM_WORDS);
    // Byte offsets are dropped: every access is a full word with strobes.
    assign unused_addr_lsbs = &{1'b0, mips_cpu_axi_if_awaddr[1:0], mips_cpu_axi_if_araddr[1:0]};

    // Transaction FSM with all AXI and memory outputs registered.
    always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
        if (!mips_cpu_reset_n) begin
            state                   <= IDLE;
            aw_got                  <= 1'b0;
            w_got                   <= 1'b0;
            addr_q                  <= '0;
            wdata_q                 <= '0;
            wstrb_q                 <= '0;
            lat_cnt                 <= '0;
            mips_cpu_axi_if_awready <= 1'b0;
            mips_cpu_axi_if_wready  <= 1'b0;
            mips_cpu_axi_if_arready <= 1'b0;
            mips_cpu_axi_if_bvalid  <= 1'b0;
            mips_cpu_axi_if_bresp   <= 2'b00;
            mips_cpu_axi_if_rvalid  <= 1'b0;
            mips_cpu_axi_if_rresp   <= 2'b00;
            mips_cpu_axi_if_rdata   <= '0;
            mem_addr                <= '0;
            mem_wen                 <= 1'b0;
            mem_wstrb               <= '0;
            mem_wdata               <= '0;
            mem_ren                 <= 1'b0;
        end else begin
            mem_wen <= 1'b0;
            mem_ren <= 1'b0;
            case (state)
                IDLE, WR_COLLECT: begin
                    if (aw_hs) addr_q <= mips_cpu_axi_if_awaddr[ADDR_WIDTH-1:2];
                    if (w_hs) begin
                        wdata_q <= mips_cpu_axi_if_wdata;
                        wstrb_q <= mips_cpu_axi_if_wstrb;
                    end
                    aw_got                  <= aw_next;
                    w_got                   <= w_next;
                    mips_cpu_axi_if_awready <= ~aw_next;
                    mips_cpu_axi_if_wready  <= ~w_next;
                    if (aw_next && w_next) begin
                        mips_cpu_axi_if_awready <= 1'b0;
                        mips_cpu_axi_if_wready  <= 1'b0;
                        state                   <= WR_MEM;
                    end else if (aw_next || w_next) begin
                        state <= WR_COLLECT;
                    end else if (mips_cpu_axi_if_arready) begin
                        // AR offered this cycle with the write channels closed.
                        mips_cpu_axi_if_arready <= 1'b0;
                        if (mips_cpu_axi_if_arvalid) begin
                            addr_q                  <= mips_cpu_axi_if_araddr[ADDR_WIDTH-1:2];
                            mips_cpu_axi_if_awready <= 1'b0;
                            mips_cpu_axi_if_wready  <= 1'b0;
                            state                   <= RD_MEM;
                        end
                    end else if (mips_cpu_axi_if_arvalid && !mips_cpu_axi_if_awvalid
                                 && !mips_cpu_axi_if_wvalid) begin
                        // Close the write channels while AR is offered so a write cannot slip in.
                        mips_cpu_axi_if_arready <= 1'b1;
                        mips_cpu_axi_if_awready <= 1'b0;
                        mips_cpu_axi_if_wready  <= 1'b0;
                    end
                end
                WR_MEM: begin
                    if (addr_ok) begin
                        mem_wen   <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= wdata_q;
                        mem_wstrb <= wstrb_q;
                    end
                    mips_cpu_axi_if_bresp <= addr_ok ? 2'b00 : 2'b10;
                    aw_got                <= 1'b0;
                    w_got                 <= 1'b0;
                    state                 <= WR_RESP;
                end
                WR_RESP: begin
                    if (!mips_cpu_axi_if_bvalid) begin
                        mips_cpu_axi_if_bvalid <= 1'b1;
                    end else if (mips_cpu_axi_if_bready) begin
                        mips_cpu_axi_if_bvalid  <= 1'b0;
                        mips_cpu_axi_if_awready <= 1'b1;
                        mips_cpu_axi_if_wready  <= 1'b1;
                        state                   <= IDLE;
                    end
                end
                RD_MEM: begin
                    if (addr_ok) begin
                        mem_ren  <= 1'b1;
                        mem_addr <= addr_q;
                    end
                    lat_cnt <= '0;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    // Count the memory pipeline; data is sampled once it has settled.
                    if (32'(lat_cnt) == RD_LATENCY) begin
                        mips_cpu_axi_if_rdata  <= addr_ok ? mem_rdata : 32'h0;
                        mips_cpu_axi_if_rresp  <= addr_ok ? 2'b00 : 2'b10;
                        mips_cpu_axi_if_rvalid <= 1'b1;
                        state                  <= RD_RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RD_RESP: begin
                    if (mips_cpu_axi_if_rready) begin
                        mips_cpu_axi_if_rvalid  <= 1'b0;
                        mips_cpu_axi_if_awready <= 1'b1;
                        mips_cpu_axi_if_wready  <= 1'b1;
                        state                   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
